core_if_fetch_buf: RTL and testbench

Parametrised instruction-fetch unit with a decoupling instruction buffer. It issues in-order fetch requests to instruction memory and tracks up to MAX_OUTSTANDING in-flight requests. Returned instructions are pre-decoded for static branch/jump prediction, and the unit redirects its own fetch PC. Wrong-path responses are killed, and {inst, pc, predict} entries are buffered in a FIFO toward decode. It sits between the instruction bus and the ID stage, and it accepts flush redirects from EXU.

---
 rtl/core_if_fetch_buf.sv | 174 +++++++++++++++++
 tb/tb_core_if_fetch_buf.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_if_fetch_buf.sv
// Instruction-fetch unit: in-order fetch requests, static branch/jump pre-decode with
// self-redirect, wrong-path response killing, and a decoupling buffer toward decode.
module core_if_fetch_buf #(
  parameter int                  PC_WIDTH        = 32,
  parameter int                  INST_WIDTH      = 32,
  parameter int                  FIFO_DEPTH      = 4,
  parameter int                  MAX_OUTSTANDING = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC        = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  o_req_valid,
  input  logic                  i_req_ready,
  output logic [PC_WIDTH-1:0]   o_req_addr,
  input  logic                  i_rsp_valid,
  input  logic [INST_WIDTH-1:0] i_rsp_inst,
  input  logic                  i_pipe_flush_req,
  input  logic [PC_WIDTH-1:0]   i_exu_pipe_flush_pc,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [INST_WIDTH-1:0] o_inst,
  output logic [PC_WIDTH-1:0]   o_pc,
  output logic                  o_branch_jump_predict
);

  localparam int FPW = $clog2(FIFO_DEPTH);
  localparam int FCW = FPW + 1;
  localparam int OPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OCW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int SW  = FCW + 1;
  localparam logic [OCW-1:0] OQ_MAX    = OCW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0]  CREDIT_MAX = SW'(FIFO_DEPTH);
  localparam logic [6:0]     OPC_JAL    = 7'b1101111;
  localparam logic [6:0]     OPC_BRANCH = 7'b1100011;

  logic [PC_WIDTH-1:0]   fpc_q, fpc_d;
  logic [PC_WIDTH-1:0]   oq_pc_q [MAX_OUTSTANDING];
  logic [PC_WIDTH-1:0]   oq_pc_d [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] oq_kill_q, oq_kill_d;
  logic [OPW-1:0]        oq_wptr_q, oq_wptr_d, oq_rptr_q, oq_rptr_d;
  logic [OCW-1:0]        oq_cnt_q, oq_cnt_d;
  logic [INST_WIDTH-1:0] fifo_inst_q [FIFO_DEPTH];
  logic [INST_WIDTH-1:0] fifo_inst_d [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]   fifo_pc_q [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]   fifo_pc_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_pred_q, fifo_pred_d;
  logic [FPW-1:0]        fifo_wptr_q, fifo_wptr_d, fifo_rptr_q, fifo_rptr_d;
  logic [FCW-1:0]        fifo_cnt_q, fifo_cnt_d;

  logic [PC_WIDTH-1:0] rsp_imm;
  logic                rsp_pred;
  logic                rsp_keep, redirect_now, req_fire, fifo_pop;
  logic [SW-1:0]       credit;

  function automatic logic [OPW-1:0] oq_next(input logic [OPW-1:0] p);
    return (p == OPW'(MAX_OUTSTANDING - 1)) ? '0 : p + OPW'(1);
  endfunction

  // Static prediction: JAL always taken, conditional branches taken only when backward.
  always_comb begin
    rsp_imm  = '0;
    rsp_pred = 1'b0;
    case (i_rsp_inst[6:0])
      OPC_JAL: begin
        rsp_imm  = {{(PC_WIDTH-20){i_rsp_inst[31]}}, i_rsp_inst[19:12], i_rsp_inst[20],
                    i_rsp_inst[30:21], 1'b0};
        rsp_pred = 1'b1;
      end
      OPC_BRANCH: begin
        rsp_imm  = {{(PC_WIDTH-12){i_rsp_inst[31]}}, i_rsp_inst[7], i_rsp_inst[30:25],
                    i_rsp_inst[11:8], 1'b0};
        rsp_pred = i_rsp_inst[31];
      end
      default: ;
    endcase
  end

  always_comb begin
    credit       = SW'(oq_cnt_q) + SW'(fifo_cnt_q);
    rsp_keep     = i_rsp_valid & ~oq_kill_q[oq_rptr_q] & ~i_pipe_flush_req;
    redirect_now = rsp_keep & rsp_pred;
    // Credit check reserves a FIFO slot for every in-flight request.
    o_req_valid  = ~rst & ~i_pipe_flush_req & ~redirect_now & (oq_cnt_q < OQ_MAX) &
                   (credit < CREDIT_MAX);
    o_req_addr   = fpc_q;
    req_fire     = o_req_valid & i_req_ready;
    o_valid      = (fifo_cnt_q != '0);
    fifo_pop     = o_valid & i_ready & ~i_pipe_flush_req;
    o_inst                = o_valid ? fifo_inst_q[fifo_rptr_q] : '0;
    o_pc                  = o_valid ? fifo_pc_q[fifo_rptr_q]   : '0;
    o_branch_jump_predict = o_valid & fifo_pred_q[fifo_rptr_q];
  end

  always_comb begin
    fpc_d = fpc_q;
    if (i_pipe_flush_req)  fpc_d = i_exu_pipe_flush_pc;
    else if (redirect_now) fpc_d = oq_pc_q[oq_rptr_q] + rsp_imm;
    else if (req_fire)     fpc_d = fpc_q + PC_WIDTH'(4);

    oq_pc_d   = oq_pc_q;
    oq_kill_d = oq_kill_q;
    oq_wptr_d = oq_wptr_q;
    oq_rptr_d = oq_rptr_q;
    oq_cnt_d  = oq_cnt_q;
    if (i_pipe_flush_req | redirect_now) oq_kill_d = '1;
    if (req_fire) begin
      oq_pc_d[oq_wptr_q]   = fpc_q;
      oq_kill_d[oq_wptr_q] = 1'b0;
      oq_wptr_d            = oq_next(oq_wptr_q);
    end
    if (i_rsp_valid) oq_rptr_d = oq_next(oq_rptr_q);
    case ({req_fire, i_rsp_valid})
      2'b10:   oq_cnt_d = oq_cnt_q + OCW'(1);
      2'b01:   oq_cnt_d = oq_cnt_q - OCW'(1);
      default: oq_cnt_d = oq_cnt_q;
    endcase

    fifo_inst_d = fifo_inst_q;
    fifo_pc_d   = fifo_pc_q;
    fifo_pred_d = fifo_pred_q;
    fifo_wptr_d = fifo_wptr_q;
    fifo_rptr_d = fifo_rptr_q;
    fifo_cnt_d  = fifo_cnt_q;
    if (i_pipe_flush_req) begin
      fifo_wptr_d = '0;
      fifo_rptr_d = '0;
      fifo_cnt_d  = '0;
    end else begin
      if (rsp_keep) begin
        fifo_inst_d[fifo_wptr_q] = i_rsp_inst;
        fifo_pc_d[fifo_wptr_q]   = oq_pc_q[oq_rptr_q];
        fifo_pred_d[fifo_wptr_q] = rsp_pred;
        fifo_wptr_d              = fifo_wptr_q + FPW'(1);
      end
      if (fifo_pop) fifo_rptr_d = fifo_rptr_q + FPW'(1);
      case ({rsp_keep, fifo_pop})
        2'b10:   fifo_cnt_d = fifo_cnt_q + FCW'(1);
        2'b01:   fifo_cnt_d = fifo_cnt_q - FCW'(1);
        default: fifo_cnt_d = fifo_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc_q       <= RESET_PC;
      oq_kill_q   <= '0;
      oq_wptr_q   <= '0;
      oq_rptr_q   <= '0;
      oq_cnt_q    <= '0;
      fifo_wptr_q <= '0;
      fifo_rptr_q <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      fpc_q       <= fpc_d;
      oq_kill_q   <= oq_kill_d;
      oq_wptr_q   <= oq_wptr_d;
      oq_rptr_q   <= oq_rptr_d;
      oq_cnt_q    <= oq_cnt_d;
      fifo_wptr_q <= fifo_wptr_d;
      fifo_rptr_q <= fifo_rptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

  // Payload storage carries no reset; outputs are masked by o_valid instead.
  always_ff @(posedge clk) begin
    oq_pc_q     <= oq_pc_d;
    fifo_inst_q <= fifo_inst_d;
    fifo_pc_q   <= fifo_pc_d;
    fifo_pred_q <= fifo_pred_d;
  end

endmodule

// File: tb/tb_core_if_fetch_buf.sv
// Directed bench for core_if_fetch_buf with a latency-configurable instruction memory model.
`timescale 1ns/1ps
module tb_core_if_fetch_buf;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        o_req_valid, i_req_ready;
  logic [31:0] o_req_addr;
  logic        i_rsp_valid;
  logic [31:0] i_rsp_inst;
  logic        i_pipe_flush_req;
  logic [31:0] i_exu_pipe_flush_pc;
  logic        o_valid, i_ready;
  logic [31:0] o_inst, o_pc;
  logic        o_branch_jump_predict;

  int checks = 0;
  int errors = 0;

  logic [31:0] pq_addr [$];
  int          pq_due  [$];
  int          cyc, lat;
  logic        sp0_en, sp1_en;
  logic [31:0] sp0_addr, sp0_inst, sp1_addr, sp1_inst;

  logic        s_req_valid, s_fire, s_valid, s_pred;
  logic [31:0] s_addr, s_pc, s_inst;

  core_if_fetch_buf dut (
    .clk(clk), .rst(rst),
    .o_req_valid(o_req_valid), .i_req_ready(i_req_ready), .o_req_addr(o_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_inst(i_rsp_inst),
    .i_pipe_flush_req(i_pipe_flush_req), .i_exu_pipe_flush_pc(i_exu_pipe_flush_pc),
    .o_valid(o_valid), .i_ready(i_ready), .o_inst(o_inst), .o_pc(o_pc),
    .o_branch_jump_predict(o_branch_jump_predict)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] imem(input logic [31:0] a);
    if (sp0_en && a == sp0_addr) return sp0_inst;
    if (sp1_en && a == sp1_addr) return sp1_inst;
    return {a[26:2], 7'b0010011};
  endfunction

  // One clock cycle: drive memory response, sample at negedge, record accepted request.
  task automatic step();
    logic [31:0] a;
    int          d;
    if (pq_addr.size() > 0 && pq_due[0] <= cyc) begin
      a = pq_addr.pop_front();
      d = pq_due.pop_front();
      i_rsp_valid = 1'b1;
      i_rsp_inst  = imem(a);
    end else begin
      i_rsp_valid = 1'b0;
      i_rsp_inst  = '0;
    end
    @(negedge clk);
    s_req_valid = o_req_valid;
    s_fire      = o_req_valid & i_req_ready;
    s_addr      = o_req_addr;
    s_valid     = o_valid;
    s_pc        = o_pc;
    s_inst      = o_inst;
    s_pred      = o_branch_jump_predict;
    if (s_fire) begin
      pq_addr.push_back(s_addr);
      pq_due.push_back(cyc + lat);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    i_req_ready = 1'b1;
    i_rsp_valid = 1'b0;
    i_rsp_inst = '0;
    i_pipe_flush_req = 1'b0;
    i_exu_pipe_flush_pc = '0;
    i_ready = 1'b1;
    pq_addr.delete();
    pq_due.delete();
    sp0_en = 1'b0;
    sp1_en = 1'b0;
    sp0_addr = '0; sp0_inst = '0; sp1_addr = '0; sp1_inst = '0;
    lat = 1;
    cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_req_ready = 1'b1;
    i_rsp_valid = 1'b0;
    i_rsp_inst = '0;
    i_pipe_flush_req = 1'b0;
    i_exu_pipe_flush_pc = '0;
    i_ready = 1'b1;
    sp0_en = 1'b0; sp1_en = 1'b0;
    sp0_addr = '0; sp0_inst = '0; sp1_addr = '0; sp1_inst = '0;
    lat = 1;
    cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid: got %b expected 0", o_valid); end
    checks++; if (o_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", o_req_valid); end
    checks++; if (o_inst !== 32'h0) begin errors++; $display("FAIL reset_o_inst: got %h expected 0", o_inst); end
    checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL reset_o_pc: got %h expected 0", o_pc); end
    checks++; if (o_branch_jump_predict !== 1'b0) begin errors++; $display("FAIL reset_pred: got %b expected 0", o_branch_jump_predict); end
    rst = 1'b0;
    step();
    checks++; if (s_fire !== 1'b1 || s_addr !== BASE) begin errors++; $display("FAIL first_req: got fire=%b addr=%h expected fire=1 addr=%h", s_fire, s_addr, BASE); end
  endtask

  task automatic test_sequential();
    reset_dut();
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (s_fire !== 1'b1 || s_addr !== BASE + 32'(4*k)) begin
        errors++; $display("FAIL seq_req[%0d]: got fire=%b addr=%h expected fire=1 addr=%h", k, s_fire, s_addr, BASE + 32'(4*k));
      end
      if (k == 1) begin
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL seq_latency: got o_valid=%b expected 0", s_valid); end
      end
      if (k >= 2) begin
        checks++;
        if (s_valid !== 1'b1 || s_pc !== BASE + 32'(4*(k-2)) || s_inst !== imem(BASE + 32'(4*(k-2)))) begin
          errors++; $display("FAIL seq_out[%0d]: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h", k, s_valid, s_pc, s_inst, BASE + 32'(4*(k-2)), imem(BASE + 32'(4*(k-2))));
        end
      end
    end
  endtask

  task automatic test_backward_branch();
    reset_dut();
    lat = 2;
    sp0_en = 1'b1; sp0_addr = BASE + 32'h8; sp0_inst = 32'hFE00_0CE3;
    for (int k = 0; k < 10; k++) begin
      step();
      case (k)
        0, 1, 3, 4: begin
          checks++;
          if (s_fire !== 1'b1 || s_addr !== BASE + 32'(4 * (k > 2 ? k - 1 : k))) begin
            errors++; $display("FAIL bb_req[%0d]: got fire=%b addr=%h expected fire=1 addr=%h", k, s_fire, s_addr, BASE + 32'(4 * (k > 2 ? k - 1 : k)));
          end
        end
        5: begin
          checks++; if (s_req_valid !== 1'b0) begin errors++; $display("FAIL bb_redirect_req: got o_req_valid=%b expected 0", s_req_valid); end
          checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL bb_gap: got o_valid=%b expected 0", s_valid); end
        end
        6: begin
          checks++; if (s_fire !== 1'b1 || s_addr !== BASE) begin errors++; $display("FAIL bb_target: got fire=%b addr=%h expected fire=1 addr=%h", s_fire, s_addr, BASE); end
          checks++; if (s_valid !== 1'b1 || s_pc !== BASE + 32'h8 || s_pred !== 1'b1) begin errors++; $display("FAIL bb_branch_out: got v=%b pc=%h pred=%b expected v=1 pc=%h pred=1", s_valid, s_pc, s_pred, BASE + 32'h8); end
        end
        7, 8: begin
          checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL bb_killed[%0d]: got v=%b pc=%h expected v=0", k, s_valid, s_pc); end
        end
        9: begin
          checks++; if (s_valid !== 1'b1 || s_pc !== BASE) begin errors++; $display("FAIL bb_after: got v=%b pc=%h expected v=1 pc=%h", s_valid, s_pc, BASE); end
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_jal_forward();
    reset_dut();
    sp0_en = 1'b1; sp0_addr = BASE;            sp0_inst = 32'h1000_006F;
    sp1_en = 1'b1; sp1_addr = BASE + 32'h104;  sp1_inst = 32'h0000_0463;
    step();
    step();
    checks++; if (s_req_valid !== 1'b0) begin errors++; $display("FAIL jal_redirect_req: got o_req_valid=%b expected 0", s_req_valid); end
    step();
    checks++; if (s_fire !== 1'b1 || s_addr !== BASE + 32'h100) begin errors++; $display("FAIL jal_target: got fire=%b addr=%h expected fire=1 addr=%h", s_fire, s_addr, BASE + 32'h100); end
    checks++; if (s_valid !== 1'b1 || s_pc !== BASE || s_pred !== 1'b1 || s_inst !== 32'h1000_006F) begin errors++; $display("FAIL jal_out: got v=%b pc=%h pred=%b inst=%h expected v=1 pc=%h pred=1 inst=1000006f", s_valid, s_pc, s_pred, s_inst, BASE); end
    step();
    step();
    checks++; if (s_fire !== 1'b1 || s_addr !== BASE + 32'h108) begin errors++; $display("FAIL fwd_seq_req: got fire=%b addr=%h expected fire=1 addr=%h", s_fire, s_addr, BASE + 32'h108); end
    checks++; if (s_valid !== 1'b1 || s_pc !== BASE + 32'h100) begin errors++; $display("FAIL jal_tgt_out: got v=%b pc=%h expected v=1 pc=%h", s_valid, s_pc, BASE + 32'h100); end
    step();
    checks++; if (s_valid !== 1'b1 || s_pc !== BASE + 32'h104 || s_pred !== 1'b0) begin errors++; $display("FAIL fwd_branch_out: got v=%b pc=%h pred=%b expected v=1 pc=%h pred=0", s_valid, s_pc, s_pred, BASE + 32'h104); end
    checks++; if (s_fire !== 1'b1 || s_addr !== BASE + 32'h10C) begin errors++; $display("FAIL fwd_no_redirect: got fire=%b addr=%h expected fire=1 addr=%h", s_fire, s_addr, BASE + 32'h10C); end
  endtask

  task automatic test_full_stall();
    int fires;
    int nexp;
    reset_dut();
    i_ready = 1'b0;
    fires = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (s_fire) fires++;
    end
    checks++; if (fires !== 4) begin errors++; $display("FAIL stall_req_count: got %0d expected 4", fires); end
    checks++; if (s_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req_blocked: got o_req_valid=%b expected 0", s_req_valid); end
    checks++; if (s_valid !== 1'b1 || s_pc !== BASE) begin errors++; $display("FAIL stall_head: got v=%b pc=%h expected v=1 pc=%h", s_valid, s_pc, BASE); end
    i_ready = 1'b1;
    nexp = 0;
    for (int k = 0; k < 30 && nexp < 8; k++) begin
      step();
      if (s_valid) begin
        checks++;
        if (s_pc !== BASE + 32'(4*nexp)) begin errors++; $display("FAIL stall_drain[%0d]: got pc=%h expected %h", nexp, s_pc, BASE + 32'(4*nexp)); end
        nexp++;
      end
    end
    checks++; if (nexp !== 8) begin errors++; $display("FAIL stall_drain_timeout: got %0d outputs expected 8", nexp); end
  endtask

  task automatic test_flush();
    int found;
    reset_dut();
    lat = 2;
    i_ready = 1'b0;
    repeat (5) step();
    checks++; if (s_fire !== 1'b1 || s_addr !== BASE + 32'hC || s_valid !== 1'b1 || s_pc !== BASE) begin errors++; $display("FAIL flush_setup: got fire=%b addr=%h v=%b pc=%h expected fire=1 addr=%h v=1 pc=%h", s_fire, s_addr, s_valid, s_pc, BASE + 32'hC, BASE); end
    i_pipe_flush_req = 1'b1;
    i_exu_pipe_flush_pc = BASE + 32'h200;
    i_ready = 1'b1;
    step();
    checks++; if (s_req_valid !== 1'b0) begin errors++; $display("FAIL flush_req_blocked: got o_req_valid=%b expected 0", s_req_valid); end
    i_pipe_flush_req = 1'b0;
    step();
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL flush_o_valid: got %b expected 0", s_valid); end
    checks++; if (s_fire !== 1'b1 || s_addr !== BASE + 32'h200) begin errors++; $display("FAIL flush_req_pc: got fire=%b addr=%h expected fire=1 addr=%h", s_fire, s_addr, BASE + 32'h200); end
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      step();
      if (s_valid) begin
        found = 1;
        checks++;
        if (s_pc !== BASE + 32'h200) begin errors++; $display("FAIL flush_first_out: got pc=%h expected %h", s_pc, BASE + 32'h200); end
      end
    end
    checks++; if (found !== 1) begin errors++; $display("FAIL flush_timeout: got no output expected pc %h", BASE + 32'h200); end
  endtask

  task automatic test_flush_jal();
    reset_dut();
    sp0_en = 1'b1; sp0_addr = BASE + 32'h4; sp0_inst = 32'h1000_006F;
    step();
    step();
    i_pipe_flush_req = 1'b1;
    i_exu_pipe_flush_pc = BASE + 32'h300;
    step();
    checks++; if (s_req_valid !== 1'b0) begin errors++; $display("FAIL fj_req_blocked: got o_req_valid=%b expected 0", s_req_valid); end
    i_pipe_flush_req = 1'b0;
    step();
    checks++; if (s_fire !== 1'b1 || s_addr !== BASE + 32'h300) begin errors++; $display("FAIL fj_flush_wins: got fire=%b addr=%h expected fire=1 addr=%h", s_fire, s_addr, BASE + 32'h300); end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL fj_o_valid: got %b expected 0", s_valid); end
    step();
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL fj_jal_dropped: got v=%b pc=%h expected v=0", s_valid, s_pc); end
    step();
    checks++; if (s_valid !== 1'b1 || s_pc !== BASE + 32'h300 || s_pred !== 1'b0) begin errors++; $display("FAIL fj_first_out: got v=%b pc=%h pred=%b expected v=1 pc=%h pred=0", s_valid, s_pc, s_pred, BASE + 32'h300); end
  endtask

  task automatic test_async_reset();
    reset_dut();
    repeat (3) step();
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL areset_pre: got o_valid=%b expected 1", o_valid); end
    rst = 1'b1;
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL areset_o_valid: got %b expected 0", o_valid); end
    checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL areset_o_pc: got %h expected 0", o_pc); end
    checks++; if (o_req_valid !== 1'b0) begin errors++; $display("FAIL areset_req: got %b expected 0", o_req_valid); end
    reset_dut();
    step();
    checks++; if (s_fire !== 1'b1 || s_addr !== BASE) begin errors++; $display("FAIL areset_restart: got fire=%b addr=%h expected fire=1 addr=%h", s_fire, s_addr, BASE); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backward_branch();
    test_jal_forward();
    test_full_stall();
    test_flush();
    test_flush_jal();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
